// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
// Holds the FSM state encoding, the external game-state codes, the LFSR tap
// mask and small helpers used by the sequencer and its LFSR.
package mole_game_pkg;

    // Internal sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StSpawn,
        StWait,
        StOver
    } state_e;

    // Codes presented on game_state_o.
    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_OVER = 2'b10;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Four-digit display ceiling.
    localparam int unsigned SCORE_MAX_DEFAULT = 9999;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Never light the same hole twice in a row.
    function automatic logic [3:0] pick_idx(input logic [3:0] raw, input logic [3:0] prev);
        return (raw == prev) ? raw + 4'd1 : raw;
    endfunction

    // External code for an internal state.
    function automatic logic [1:0] game_state_code(input state_e s);
        logic [1:0] code;
        code = GS_IDLE;
        unique case (s)
            StIdle:                 code = GS_IDLE;
            StGap, StSpawn, StWait: code = GS_PLAY;
            StOver:                 code = GS_OVER;
            default:                code = GS_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used to pick mole positions.
// Ports:
//   clock_i - system clock
//   reset_i - asynchronous active-low reset, loads SEED
//   lfsr_o  - current LFSR value, advances every cycle
module mole_lfsr
    import mole_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign lfsr_o = r_lfsr;

endmodule

// File: rtl/mole_game_sequencer.sv
// Whack-a-mole round controller. Places one mole at a time at a pseudo-random
// position, scores switch rising edges against the lit mole, penalises wrong
// switches, counts the round down and reports state for the display path.
// Ports:
//   clock_i      - system clock
//   reset_i      - asynchronous active-low reset
//   mode_i       - difficulty; 00 means no mode selected (start is refused)
//   start_i      - single-cycle start/restart pulse
//   sec_tick_i   - single-cycle 1 Hz enable
//   mole_tick_i  - single-cycle mole-rate enable
//   switches_i   - synchronized switch levels
//   leds_o       - one-hot mole position or zero
//   score_o      - binary score, saturating
//   time_left_o  - binary seconds remaining
//   game_state_o - 00 idle, 01 play, 10 over
//   show_score_o - display select: 1 score, 0 time
module mole_game_sequencer
    import mole_game_pkg::*;
#(
    parameter int unsigned GAME_SECONDS = 30,
    parameter int unsigned MOLE_TIMEOUT = 3,
    parameter int unsigned SCORE_MAX    = SCORE_MAX_DEFAULT,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [1:0]  mode_i,
    input  logic        start_i,
    input  logic        sec_tick_i,
    input  logic        mole_tick_i,
    input  logic [15:0] switches_i,
    output logic [15:0] leds_o,
    output logic [15:0] score_o,
    output logic [7:0]  time_left_o,
    output logic [1:0]  game_state_o,
    output logic        show_score_o
);

    localparam logic [7:0]  GameSecs = 8'(GAME_SECONDS);
    localparam logic [3:0]  MoleTmo  = 4'(MOLE_TIMEOUT);
    localparam logic [15:0] ScoreMax = 16'(SCORE_MAX);

    state_e      r_state, w_state_d;
    logic [15:0] r_leds, w_leds_d;
    logic [15:0] r_score, w_score_d;
    logic [7:0]  r_time, w_time_d;
    logic [3:0]  r_tmo, w_tmo_d;
    logic [3:0]  r_prev_idx, w_prev_idx_d;
    logic [15:0] r_sw_q;
    logic [1:0]  r_game_state;
    logic        r_show_score;

    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;
    logic [15:0] w_rise;
    logic        w_hit;
    logic        w_wrong;
    logic        w_playing;
    logic        w_start_ok;
    logic        w_game_end;
    logic [3:0]  w_spawn_idx;

    mole_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .lfsr_o (w_lfsr)
    );

    // Only the low nibble selects a hole.
    assign w_unused_lfsr = ^w_lfsr[15:4];

    assign w_rise      = switches_i & ~r_sw_q;
    assign w_hit       = |(w_rise & r_leds);
    assign w_wrong     = |(w_rise & ~r_leds) & ~w_hit;
    assign w_playing   = (r_state == StGap) || (r_state == StSpawn) || (r_state == StWait);
    assign w_start_ok  = start_i && (mode_i != 2'b00);
    assign w_game_end  = w_playing && sec_tick_i && (r_time == 8'd1);
    assign w_spawn_idx = pick_idx(w_lfsr[3:0], r_prev_idx);

    always_comb begin
        w_state_d    = r_state;
        w_leds_d     = r_leds;
        w_score_d    = r_score;
        w_time_d     = r_time;
        w_tmo_d      = r_tmo;
        w_prev_idx_d = r_prev_idx;

        unique case (r_state)
            StIdle, StOver: begin
                w_leds_d = '0;
                if (w_start_ok) begin
                    w_state_d = StGap;
                    w_score_d = '0;
                    w_time_d  = GameSecs;
                end
            end
            StGap: begin
                w_leds_d = '0;
                if (mole_tick_i) begin
                    w_state_d = StSpawn;
                end
            end
            StSpawn: begin
                w_leds_d     = 16'd1 << w_spawn_idx;
                w_prev_idx_d = w_spawn_idx;
                w_tmo_d      = MoleTmo;
                w_state_d    = StWait;
            end
            StWait: begin
                if (w_hit) begin
                    if (r_score < ScoreMax) begin
                        w_score_d = r_score + 16'd1;
                    end
                    w_leds_d  = '0;
                    w_state_d = StGap;
                end else if (mole_tick_i) begin
                    if (r_tmo == 4'd1) begin
                        // Missed: relight straight away without a gap.
                        w_leds_d  = '0;
                        w_state_d = StSpawn;
                    end else begin
                        w_tmo_d = r_tmo - 4'd1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_leds_d  = '0;
            end
        endcase

        // Hit and wrong are mutually exclusive, so this never undoes a hit.
        if (w_playing && w_wrong && (r_score != 16'd0)) begin
            w_score_d = r_score - 16'd1;
        end

        if (w_playing && sec_tick_i) begin
            w_time_d = r_time - 8'd1;
        end

        // Round end overrides everything else decided this cycle.
        if (w_game_end) begin
            w_state_d    = StOver;
            w_leds_d     = '0;
            w_score_d    = r_score;
            w_time_d     = '0;
            w_tmo_d      = r_tmo;
            w_prev_idx_d = r_prev_idx;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state      <= StIdle;
            r_leds       <= '0;
            r_score      <= '0;
            r_time       <= '0;
            r_tmo        <= '0;
            r_prev_idx   <= '0;
            r_sw_q       <= '0;
            r_game_state <= GS_IDLE;
            r_show_score <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_leds       <= w_leds_d;
            r_score      <= w_score_d;
            r_time       <= w_time_d;
            r_tmo        <= w_tmo_d;
            r_prev_idx   <= w_prev_idx_d;
            r_sw_q       <= switches_i;
            r_game_state <= game_state_code(w_state_d);
            r_show_score <= (w_state_d == StOver);
        end
    end

    assign leds_o       = r_leds;
    assign score_o      = r_score;
    assign time_left_o  = r_time;
    assign game_state_o = r_game_state;
    assign show_score_o = r_show_score;

endmodule

// File: tb/tb_mole_game_sequencer.sv
// Self-checking bench for mole_game_sequencer: a constant vector table, hand
// sequences for the multi-cycle corners, and a randomized run against a
// behavioural game model.
module tb_mole_game_sequencer;

    localparam int          GAME_S = 30;
    localparam int          TMO    = 3;
    localparam int          SMAX   = 9999;
    localparam logic [15:0] SEED   = 16'hACE1;

    localparam int M_IDLE  = 0;
    localparam int M_GAP   = 1;
    localparam int M_SPAWN = 2;
    localparam int M_WAIT  = 3;
    localparam int M_OVER  = 4;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic        start_i = 1'b0;
    logic        sec_tick_i = 1'b0;
    logic        mole_tick_i = 1'b0;
    logic [15:0] switches_i = 16'h0000;
    logic [15:0] leds_o;
    logic [15:0] score_o;
    logic [7:0]  time_left_o;
    logic [1:0]  game_state_o;
    logic        show_score_o;

    always #5 clock_i = ~clock_i;

    mole_game_sequencer #(
        .GAME_SECONDS(GAME_S),
        .MOLE_TIMEOUT(TMO),
        .SCORE_MAX   (SMAX),
        .LFSR_SEED   (SEED)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .mode_i      (mode_i),
        .start_i     (start_i),
        .sec_tick_i  (sec_tick_i),
        .mole_tick_i (mole_tick_i),
        .switches_i  (switches_i),
        .leds_o      (leds_o),
        .score_o     (score_o),
        .time_left_o (time_left_o),
        .game_state_o(game_state_o),
        .show_score_o(show_score_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the game.
    int          m_ph;
    logic [15:0] m_lfsr;
    logic [15:0] m_swq;
    int          m_prev;
    int          m_tmo;
    int          m_score;
    int          m_tleft;
    logic [15:0] m_leds;

    int          poly_exps[4] = '{16, 14, 13, 11};
    logic [15:0] taps;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? taps : 16'h0000);
    endfunction

    task automatic model_reset();
        m_ph = M_IDLE; m_lfsr = SEED; m_swq = '0; m_prev = 0;
        m_tmo = 0; m_score = 0; m_tleft = 0; m_leds = '0;
    endtask

    task automatic model_step();
        logic [15:0] rise;
        logic        hit, wrong, play;
        int          idx;
        rise  = switches_i & ~m_swq;
        hit   = (rise & m_leds) != 16'h0;
        wrong = !hit && ((rise & ~m_leds) != 16'h0);
        play  = (m_ph == M_GAP) || (m_ph == M_SPAWN) || (m_ph == M_WAIT);
        idx   = int'(m_lfsr[3:0]);
        if (idx == m_prev) idx = (idx + 1) % 16;
        if (play && sec_tick_i && m_tleft == 1) begin
            m_tleft = 0; m_leds = '0; m_ph = M_OVER;
        end else begin
            if (play && sec_tick_i) m_tleft = m_tleft - 1;
            if (play && wrong && m_score > 0) m_score = m_score - 1;
            case (m_ph)
                M_IDLE, M_OVER: if (start_i && mode_i != 2'b00) begin
                    m_ph = M_GAP; m_score = 0; m_tleft = GAME_S; m_leds = '0;
                end
                M_GAP: if (mole_tick_i) m_ph = M_SPAWN;
                M_SPAWN: begin
                    m_leds = 16'h0001 << idx; m_prev = idx; m_tmo = TMO; m_ph = M_WAIT;
                end
                M_WAIT: begin
                    if (hit) begin
                        if (m_score < SMAX) m_score = m_score + 1;
                        m_leds = '0; m_ph = M_GAP;
                    end else if (mole_tick_i) begin
                        if (m_tmo == 1) begin
                            m_leds = '0; m_ph = M_SPAWN;
                        end else begin
                            m_tmo = m_tmo - 1;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_swq  = switches_i;
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        logic [42:0] a, e;
        logic [1:0]  gs;
        gs = (m_ph == M_OVER) ? 2'b10 : ((m_ph == M_IDLE) ? 2'b00 : 2'b01);
        a = {leds_o, score_o, time_left_o, game_state_o, show_score_o};
        e = {m_leds, 16'(m_score), 8'(m_tleft), gs, (m_ph == M_OVER)};
        chk(name, {21'd0, a}, {21'd0, e});
    endtask

    function automatic logic [42:0] all_outs();
        return {leds_o, score_o, time_left_o, game_state_o, show_score_o};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic clear_inputs();
        start_i = 1'b0; sec_tick_i = 1'b0; mole_tick_i = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]  mode;
        logic        start;
        logic        sec;
        logic        mole;
        logic [15:0] sw;
        logic [1:0]  e_gs;
        logic [7:0]  e_time;
        logic [15:0] e_score;
        logic        e_show;
        logic [15:0] e_leds;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] mode, input logic start, input logic sec,
                                input logic mole, input logic [15:0] sw, input logic [1:0] gs,
                                input logic [7:0] t, input logic [15:0] s, input logic show);
        vec_t v;
        v = '{mode: mode, start: start, sec: sec, mole: mole, sw: sw, e_gs: gs, e_time: t,
              e_score: s, e_show: show, e_leds: 16'h0000};
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] old_leds;
        logic [15:0] nl;
        logic [3:0]  pidx;
        int          budget;
        int          r;

        taps = '0;
        foreach (poly_exps[i]) taps[poly_exps[i] - 1] = 1'b1;
        model_reset();

        vecs[0] = mk(2'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 8'd0,  16'd0, 1'b0);
        vecs[1] = mk(2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 8'd0,  16'd0, 1'b0);
        vecs[2] = mk(2'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'd30, 16'd0, 1'b0);
        vecs[3] = mk(2'd1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 8'd29, 16'd0, 1'b0);
        vecs[4] = mk(2'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 8'd29, 16'd0, 1'b0);
        vecs[5] = mk(2'd2, 1'b0, 1'b0, 1'b0, 16'h0008, 2'd1, 8'd29, 16'd0, 1'b0);
        vecs[6] = mk(2'd0, 1'b0, 1'b1, 1'b0, 16'h0008, 2'd1, 8'd28, 16'd0, 1'b0);
        vecs[7] = mk(2'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd1, 8'd28, 16'd0, 1'b0);

        // Power-on reset.
        @(posedge clock_i);
        @(posedge clock_i);
        #1;
        chk("reset_outputs", {21'd0, all_outs()}, 64'd0);
        reset_i = 1'b1;

        // Vector table from idle into the first spawn.
        for (int i = 0; i < 8; i++) begin
            mode_i = vecs[i].mode; start_i = vecs[i].start; sec_tick_i = vecs[i].sec;
            mole_tick_i = vecs[i].mole; switches_i = vecs[i].sw;
            tick();
            chk($sformatf("vec%0d", i),
                {21'd0, leds_o, score_o, time_left_o, game_state_o, show_score_o},
                {21'd0, vecs[i].e_leds, vecs[i].e_score, vecs[i].e_time, vecs[i].e_gs,
                 vecs[i].e_show});
            chk_model($sformatf("vec%0d_model", i));
        end
        clear_inputs();
        switches_i = '0;

        // Steer the mole onto hole 8, whacking any other position.
        budget = 3000;
        while (!(m_ph == M_WAIT && m_leds == 16'h0100) && budget > 0) begin
            clear_inputs();
            switches_i = '0;
            if (m_ph == M_GAP) begin
                nl   = lfsr_adv(m_lfsr);
                pidx = nl[3:0];
                if (int'(pidx) == m_prev) pidx = pidx + 4'd1;
                if (pidx == 4'd8) mole_tick_i = 1'b1;
            end else if (m_ph == M_WAIT) begin
                switches_i = m_leds;
            end
            tick();
            budget--;
        end
        clear_inputs();
        switches_i = '0;
        chk("wait_led_0100", {48'd0, leds_o}, {48'd0, 16'h0100});
        chk("wait_state_play", {62'd0, game_state_o}, 64'd1);

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset_i = 1'b0;
        #1;
        chk("async_reset_outputs", {21'd0, all_outs()}, 64'd0);
        model_reset();
        @(posedge clock_i);
        #1;
        reset_i = 1'b1;

        mode_i = 2'b00; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk("start_mode00_ignored", {62'd0, game_state_o}, 64'd0);

        // Start a round and spawn the first mole.
        mode_i = 2'b01; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start_state", {62'd0, game_state_o}, 64'd1);
        chk("start_time", {56'd0, time_left_o}, 64'd30);
        mole_tick_i = 1'b1;
        tick();
        mole_tick_i = 1'b0;
        tick();
        chk("spawn_onehot", {63'd0, $onehot(leds_o)}, 64'd1);
        chk("spawn_time", {56'd0, time_left_o}, 64'd30);
        chk("spawn_score", {48'd0, score_o}, 64'd0);
        chk_model("spawn_model");

        // Hit, then two wrong switches floored at zero.
        switches_i = m_leds;
        tick();
        chk("hit_score", {48'd0, score_o}, 64'd1);
        chk("hit_leds_clear", {48'd0, leds_o}, 64'd0);
        switches_i = '0;
        tick();
        switches_i = 16'h0001;
        tick();
        chk("wrong1_score", {48'd0, score_o}, 64'd0);
        switches_i = '0;
        tick();
        switches_i = 16'h0001;
        tick();
        chk("wrong2_floor", {48'd0, score_o}, 64'd0);
        switches_i = '0;
        tick();

        // Miss after MOLE_TIMEOUT mole ticks.
        mole_tick_i = 1'b1;
        tick();
        mole_tick_i = 1'b0;
        tick();
        old_leds = leds_o;
        for (int k = 0; k < TMO; k++) begin
            mole_tick_i = 1'b1;
            tick();
            mole_tick_i = 1'b0;
            tick();
        end
        chk("miss_onehot", {63'd0, $onehot(leds_o)}, 64'd1);
        chk("miss_new_pos", {63'd0, (leds_o != old_leds)}, 64'd1);
        chk("miss_score", {48'd0, score_o}, 64'd0);
        chk_model("miss_model");

        // Run the clock out; the hit on the final tick must not score.
        for (int k = 0; k < GAME_S - 1; k++) begin
            sec_tick_i = 1'b1;
            tick();
            sec_tick_i = 1'b0;
            tick();
        end
        chk("time_one_left", {56'd0, time_left_o}, 64'd1);
        sec_tick_i = 1'b1;
        switches_i = m_leds;
        tick();
        chk("over_outputs", {21'd0, all_outs()}, {21'd0, 16'h0000, 16'd0, 8'd0, 2'b10, 1'b1});
        sec_tick_i = 1'b0;
        switches_i = '0;
        tick();

        // Restart from OVER.
        mode_i = 2'b10; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_outputs", {21'd0, all_outs()}, {21'd0, 16'h0000, 16'd0, 8'd30, 2'b01, 1'b0});

        // Climb to the score ceiling.
        budget = 40000;
        while (m_score < SMAX && budget > 0) begin
            clear_inputs();
            switches_i = '0;
            if (m_ph == M_GAP) mole_tick_i = 1'b1;
            else if (m_ph == M_WAIT) switches_i = m_leds;
            tick();
            budget--;
        end
        clear_inputs();
        switches_i = '0;
        chk("score_at_max", {48'd0, score_o}, 64'd9999);
        mole_tick_i = 1'b1;
        tick();
        mole_tick_i = 1'b0;
        tick();
        switches_i = m_leds;
        tick();
        chk("score_saturates", {48'd0, score_o}, 64'd9999);
        chk("sat_hit_leds_clear", {48'd0, leds_o}, 64'd0);
        switches_i = '0;
        tick();
        switches_i = 16'h8000;
        tick();
        chk("penalty_from_max", {48'd0, score_o}, 64'd9998);
        switches_i = '0;
        tick();

        // Randomized play against the model.
        reset_i = 1'b0;
        model_reset();
        @(posedge clock_i);
        #1;
        reset_i = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            mode_i      = 2'($urandom_range(0, 3));
            start_i     = ($urandom_range(0, 29) == 0);
            sec_tick_i  = ($urandom_range(0, 9) == 0);
            mole_tick_i = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 7));
            if (r == 0) switches_i = 16'($urandom);
            else if (r < 3) switches_i = switches_i | m_leds;
            else if (r == 3) switches_i = switches_i ^ (16'h0001 << $urandom_range(0, 15));
            else if (r == 4) switches_i = '0;
            tick();
            chk_model("random_cycle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
